// File: rtl/if_fetch_pkg.sv
// -----------------------------------------------------------------------------
// if_fetch_pkg
// Shared definitions for the instruction-fetch stage: bus widths, stall
// encodings, the reset fetch address, bus layouts and a small alignment helper.
// -----------------------------------------------------------------------------
package if_fetch_pkg;

    localparam int          STALL_BUS_W = 6;
    localparam int          BR_WD       = 33;
    localparam int          IF_TO_ID_WD = 33;

    localparam logic        STOP        = 1'b1;
    localparam logic        NO_STOP     = 1'b0;

    localparam logic [31:0] PC_RESET    = 32'hBFC0_0000;
    localparam logic [31:0] PC_STEP     = 32'd4;

    // {br_e, br_addr} as driven by ID
    typedef struct packed {
        logic        br_e;
        logic [31:0] br_addr;
    } br_bus_t;

    // {ce, pc} as consumed by ID
    typedef struct packed {
        logic        ce;
        logic [31:0] pc;
    } if_to_id_t;

    // A fetch address is misaligned when it is not on a word boundary
    function automatic logic pc_misaligned(input logic [31:0] pc);
        return (pc[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/if_fetch_if.sv
// -----------------------------------------------------------------------------
// if_fetch_if
// Bundles the fetch stage's pipeline and instruction-SRAM signals.
//   master : the fetch stage (drives if_to_id_bus, if_inst, if_adel, SRAM req)
//   slave  : the environment (ID stage / stall control / instruction SRAM)
// Signals:
//   stall           - pipeline stall vector, bit 0 freezes PC, bit 1 = ID holds
//   br_bus          - {br_e, br_addr} from ID
//   if_to_id_bus    - {ce, pc} to ID
//   if_inst         - stall-stable instruction word to ID
//   if_adel         - current fetch PC is misaligned
//   inst_sram_*     - synchronous instruction SRAM port
// -----------------------------------------------------------------------------
interface if_fetch_if;
    import if_fetch_pkg::*;

    logic [STALL_BUS_W-1:0] stall;
    logic [BR_WD-1:0]       br_bus;
    logic [IF_TO_ID_WD-1:0] if_to_id_bus;
    logic [31:0]            if_inst;
    logic                   if_adel;
    logic                   inst_sram_en;
    logic [3:0]             inst_sram_wen;
    logic [31:0]            inst_sram_addr;
    logic [31:0]            inst_sram_wdata;
    logic [31:0]            inst_sram_rdata;

    modport master (
        input  stall,
        input  br_bus,
        input  inst_sram_rdata,
        output if_to_id_bus,
        output if_inst,
        output if_adel,
        output inst_sram_en,
        output inst_sram_wen,
        output inst_sram_addr,
        output inst_sram_wdata
    );

    modport slave (
        output stall,
        output br_bus,
        output inst_sram_rdata,
        input  if_to_id_bus,
        input  if_inst,
        input  if_adel,
        input  inst_sram_en,
        input  inst_sram_wen,
        input  inst_sram_addr,
        input  inst_sram_wdata
    );

endinterface

// File: rtl/if_fetch_inst_hold_buf.sv
// -----------------------------------------------------------------------------
// inst_hold_buf
// Keeps the instruction word seen by ID constant while ID is stalled. The SRAM
// read data keeps moving when only ID stalls (the PC still advances), so the
// word present on the first stalled cycle is captured and replayed until the
// stall releases.
// Ports:
//   clk, resetn - clock, asynchronous active-low reset
//   stall_id    - ID-hold stall bit (STOP = ID is holding its input)
//   rdata       - raw instruction SRAM read data
//   inst        - instruction word presented to ID
// -----------------------------------------------------------------------------
module inst_hold_buf
    import if_fetch_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        stall_id,
    input  logic [31:0] rdata,
    output logic [31:0] inst
);

    logic        hold_v_r;
    logic [31:0] hold_inst_r;

    // Capture the first stalled word once; drop the hold when ID moves again
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hold_v_r    <= 1'b0;
            hold_inst_r <= 32'h0000_0000;
        end else if (stall_id == STOP) begin
            if (!hold_v_r) begin
                hold_v_r    <= 1'b1;
                hold_inst_r <= rdata;
            end else begin
                hold_v_r    <= hold_v_r;
                hold_inst_r <= hold_inst_r;
            end
        end else begin
            hold_v_r    <= 1'b0;
            hold_inst_r <= hold_inst_r;
        end
    end

    assign inst = hold_v_r ? hold_inst_r : rdata;

endmodule

// File: rtl/if_fetch.sv
// -----------------------------------------------------------------------------
// if_fetch
// Instruction-fetch stage of the 5-stage MIPS pipeline. Owns the PC, applies
// branch redirects from ID (remembering one that arrives while the PC is
// frozen), drives the synchronous instruction SRAM and hands {ce, pc} plus a
// stall-stable instruction word to ID.
// Ports:
//   clk     - sole clock
//   resetn  - asynchronous active-low reset
//   bus     - if_fetch_if.master (stall, br_bus, if_to_id_bus, if_inst,
//             if_adel, inst_sram_*)
// Parameter:
//   RESET_PC - first fetch address after reset
// -----------------------------------------------------------------------------
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = PC_RESET
)
(
    input  logic          clk,
    input  logic          resetn,
    if_fetch_if.master    bus
);

    br_bus_t     br_s;
    logic        stop_pc_s;
    logic [31:0] next_pc_s;
    logic        adel_s;
    logic [31:0] if_inst_s;

    logic [31:0] pc_r;
    logic        ce_r;
    logic        redir_v_r;
    logic [31:0] redir_addr_r;

    assign br_s      = br_bus_t'(bus.br_bus);
    assign stop_pc_s = (bus.stall[0] == STOP);

    // Next fetch address: a live branch beats a remembered one, else sequential
    always_comb begin
        next_pc_s = pc_r + PC_STEP;
        if (br_s.br_e) begin
            next_pc_s = br_s.br_addr;
        end else if (redir_v_r) begin
            next_pc_s = redir_addr_r;
        end else begin
            next_pc_s = pc_r + PC_STEP;
        end
    end

    // PC / fetch-enable update; a branch seen while frozen is parked (latest wins)
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pc_r         <= RESET_PC - PC_STEP;
            ce_r         <= 1'b0;
            redir_v_r    <= 1'b0;
            redir_addr_r <= 32'h0000_0000;
        end else if (!stop_pc_s) begin
            pc_r         <= next_pc_s;
            ce_r         <= 1'b1;
            redir_v_r    <= 1'b0;
            redir_addr_r <= redir_addr_r;
        end else if (br_s.br_e) begin
            pc_r         <= pc_r;
            ce_r         <= ce_r;
            redir_v_r    <= 1'b1;
            redir_addr_r <= br_s.br_addr;
        end else begin
            pc_r         <= pc_r;
            ce_r         <= ce_r;
            redir_v_r    <= redir_v_r;
            redir_addr_r <= redir_addr_r;
        end
    end

    assign adel_s = ce_r & pc_misaligned(pc_r);

    // Enable drops during a PC stall so the SRAM output register keeps its word
    assign bus.inst_sram_en    = ce_r & ~stop_pc_s & ~adel_s;
    assign bus.inst_sram_wen   = 4'b0000;
    assign bus.inst_sram_addr  = pc_r;
    assign bus.inst_sram_wdata = 32'h0000_0000;

    assign bus.if_adel         = adel_s;
    assign bus.if_to_id_bus    = {ce_r, pc_r};

    inst_hold_buf u_hold (
        .clk      (clk),
        .resetn   (resetn),
        .stall_id (bus.stall[1]),
        .rdata    (bus.inst_sram_rdata),
        .inst     (if_inst_s)
    );

    assign bus.if_inst = if_inst_s;

endmodule

// File: tb/tb_if_fetch.sv
// -----------------------------------------------------------------------------
// tb_if_fetch
// Self-checking bench for if_fetch: directed scenarios followed by random
// stall / branch / reset traffic, compared against a behavioural model of the
// fetch stage and its instruction SRAM.
// -----------------------------------------------------------------------------
module tb_if_fetch;

    logic clk = 1'b0;
    logic resetn;

    if_fetch_if bus ();

    if_fetch #(.RESET_PC(32'hBFC0_0000)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    // Instruction memory contents: a distinct word for every address
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hA5C3_96E1;
    endfunction

    // Synchronous SRAM: data for the address one cycle later, held when disabled
    logic [31:0] sram_q = 32'h0000_0000;
    always @(posedge clk) begin
        if (bus.inst_sram_en) sram_q <= mem_word(bus.inst_sram_addr);
    end
    assign bus.inst_sram_rdata = sram_q;

    // ---------------- reference model state ----------------
    logic [31:0] m_pc;
    logic        m_ce;
    logic        m_rv;   // redirect remembered from a frozen cycle
    logic [31:0] m_ra;
    logic        m_hv;   // ID-side word is being held
    logic [31:0] m_hi;
    logic [31:0] m_rd = 32'h0000_0000;  // what the SRAM is presenting

    int n_vec = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = 32'hBFC0_0000 - 32'd4;
        m_ce = 1'b0;
        m_rv = 1'b0;
        m_ra = 32'h0000_0000;
        m_hv = 1'b0;
        m_hi = 32'h0000_0000;
    endtask

    function automatic logic exp_adel();
        return m_ce && ((m_pc % 32'd4) != 32'd0);
    endfunction

    // Compare every DUT output against the model for the inputs now applied
    task automatic check_outputs();
        logic [5:0] st;
        logic       en;
        st = bus.stall;
        en = m_ce && !st[0] && !exp_adel();
        check_eq("sram_addr", 64'(bus.inst_sram_addr), 64'(m_pc));
        check_eq("sram_en",   64'(bus.inst_sram_en),   64'(en));
        check_eq("sram_wen",  64'(bus.inst_sram_wen),  64'd0);
        check_eq("sram_wdata",64'(bus.inst_sram_wdata),64'd0);
        check_eq("if_to_id",  64'(bus.if_to_id_bus),   64'({m_ce, m_pc}));
        check_eq("if_adel",   64'(bus.if_adel),        64'(exp_adel()));
        check_eq("if_inst",   64'(bus.if_inst),        64'(m_hv ? m_hi : m_rd));
    endtask

    // Effect of one rising clock edge with the given inputs
    task automatic model_edge(input logic [5:0] st, input logic be, input logic [31:0] ba);
        logic [31:0] word_before;
        word_before = m_rd;
        if (m_ce && !st[0] && !exp_adel()) m_rd = mem_word(m_pc);
        if (st[1]) begin
            if (!m_hv) begin
                m_hi = word_before;
                m_hv = 1'b1;
            end
        end else begin
            m_hv = 1'b0;
        end
        if (!st[0]) begin
            if (be)        m_pc = ba;
            else if (m_rv) m_pc = m_ra;
            else           m_pc = m_pc + 32'd4;
            m_ce = 1'b1;
            m_rv = 1'b0;
        end else if (be) begin
            m_rv = 1'b1;
            m_ra = ba;
        end
    endtask

    // Apply inputs for one cycle, check mid-cycle, then advance past the edge
    task automatic drive_cycle(input logic [5:0] st, input logic be, input logic [31:0] ba);
        bus.stall  = st;
        bus.br_bus = {be, ba};
        #1;
        check_outputs();
        @(posedge clk);
        model_edge(st, be, ba);
        #1;
    endtask

    // Asynchronous reset mid-cycle, held across one edge, released mid-cycle
    task automatic pulse_reset();
        resetn = 1'b0;
        #1;
        model_reset();
        check_eq("rst_bus", 64'(bus.if_to_id_bus), 64'({1'b0, 32'hBFBF_FFFC}));
        check_outputs();
        @(posedge clk);
        #1;
        resetn = 1'b1;
    endtask

    initial begin
        logic [31:0] w0;
        logic [31:0] ba;
        logic [5:0]  st;
        logic        be;

        resetn     = 1'b0;
        bus.stall  = 6'b000000;
        bus.br_bus = 33'h0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_bus", 64'(bus.if_to_id_bus), 64'({1'b0, 32'hBFBF_FFFC}));
        check_outputs();
        resetn = 1'b1;

        // sequential fetch from the reset address
        drive_cycle(6'b0, 1'b0, 32'h0);
        check_eq("seq0", 64'(bus.inst_sram_addr), 64'(32'hBFC0_0000));
        check_eq("seq0_ce", 64'(bus.if_to_id_bus[32]), 64'd1);
        drive_cycle(6'b0, 1'b0, 32'h0);
        check_eq("seq1", 64'(bus.inst_sram_addr), 64'(32'hBFC0_0004));
        drive_cycle(6'b0, 1'b0, 32'h0);
        check_eq("seq2", 64'(bus.inst_sram_addr), 64'(32'hBFC0_0008));

        // branch redirect
        drive_cycle(6'b0, 1'b1, 32'hBFC0_0100);
        check_eq("br_tgt", 64'(bus.inst_sram_addr), 64'(32'hBFC0_0100));
        drive_cycle(6'b0, 1'b0, 32'h0);
        check_eq("br_seq", 64'(bus.inst_sram_addr), 64'(32'hBFC0_0104));

        // redirect arriving during a PC stall
        drive_cycle(6'b000001, 1'b0, 32'h0);
        drive_cycle(6'b000001, 1'b1, 32'hBFC0_0200);
        drive_cycle(6'b000001, 1'b0, 32'h0);
        check_eq("stall_frz", 64'(bus.inst_sram_addr), 64'(32'hBFC0_0104));
        drive_cycle(6'b0, 1'b0, 32'h0);
        check_eq("stall_redir", 64'(bus.inst_sram_addr), 64'(32'hBFC0_0200));
        drive_cycle(6'b0, 1'b0, 32'h0);

        // hold buffer while only ID stalls (SRAM data keeps changing)
        w0 = m_hv ? m_hi : m_rd;
        for (int i = 0; i < 4; i++) begin
            bus.stall = 6'b000010;
            #1;
            check_eq("hold_inst", 64'(bus.if_inst), 64'(w0));
            #1;
            drive_cycle(6'b000010, 1'b0, 32'h0);
        end
        drive_cycle(6'b0, 1'b0, 32'h0);
        drive_cycle(6'b0, 1'b0, 32'h0);

        // misaligned branch target
        drive_cycle(6'b0, 1'b1, 32'hBFC0_0102);
        check_eq("adel", 64'(bus.if_adel), 64'd1);
        check_eq("adel_en", 64'(bus.inst_sram_en), 64'd0);
        drive_cycle(6'b0, 1'b1, 32'hBFC0_0300);
        check_eq("adel_clr", 64'(bus.if_adel), 64'd0);

        // 32-bit wrap of the sequential increment
        drive_cycle(6'b0, 1'b1, 32'hFFFF_FFFC);
        drive_cycle(6'b0, 1'b0, 32'h0);
        check_eq("wrap", 64'(bus.inst_sram_addr), 64'd0);

        // async reset with a redirect pending and ID holding
        drive_cycle(6'b000011, 1'b1, 32'hBFC0_0400);
        pulse_reset();
        drive_cycle(6'b0, 1'b0, 32'h0);
        check_eq("rst_redir_lost", 64'(bus.inst_sram_addr), 64'(32'hBFC0_0000));

        // random traffic
        for (int n = 0; n < 500; n++) begin
            if ($urandom_range(0, 99) == 0) begin
                pulse_reset();
            end
            st = 6'b0;
            st[0] = ($urandom_range(0, 3) == 0);
            st[1] = st[0] | ($urandom_range(0, 4) == 0);
            be = ($urandom_range(0, 6) == 0);
            ba = $urandom();
            if ($urandom_range(0, 7) != 0) ba[1:0] = 2'b00;
            drive_cycle(st, be, ba);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
